// File: rtl/nibble_serial_adder.sv
// Serial 16-bit adder: walks four nibbles through an external 4-bit ripple carry adder,
// one nibble per clock, LSB first. Also provides the 4-bit ripple carry adder that closes the loop.

module ripple_carry_adder4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] w_c;

  assign w_c[0] = ci;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign s[g]     = x[g] ^ y[g] ^ w_c[g];
    assign w_c[g+1] = (x[g] & y[g]) | (w_c[g] & (x[g] ^ y[g]));
  end

  assign co = w_c[4];

endmodule

module nibble_serial_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [3:0]  add_x,
  output logic [3:0]  add_y,
  output logic        add_cin,
  input  logic [3:0]  add_s,
  input  logic        add_cout,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic        w_run;
  logic        w_last;

  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_part;
  logic [15:0] r_sum;
  logic [1:0]  r_idx;
  logic        r_carry;
  logic        r_cout;

  logic [3:0]  w_nib_a;
  logic [3:0]  w_nib_b;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_run        = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept = start;
        if (start) w_next_state = S_RUN;
      end
      S_RUN: begin
        w_run  = 1'b1;
        w_last = (r_idx == 2'd3);
        if (r_idx == 2'd3) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath. The operand and partial registers are small, so they are reset
  // along with everything else to give a fully known post-reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (w_run) begin
      r_part[{r_idx, 2'b00} +: 4] <= add_s;
      r_carry                     <= add_cout;
      r_idx                       <= r_idx + 2'd1;
      // Final nibble bypasses r_part so the result lands in the same edge as DONE.
      if (w_last) begin
        r_sum  <= {add_s, r_part[11:0]};
        r_cout <= add_cout;
      end
    end
  end

  always_comb begin
    w_nib_a = r_a[{r_idx, 2'b00} +: 4];
    w_nib_b = r_b[{r_idx, 2'b00} +: 4];
  end

  // Adder inputs are forced to zero outside RUN so the external adder sees quiet inputs.
  assign add_x   = w_run ? w_nib_a : 4'h0;
  assign add_y   = w_run ? w_nib_b : 4'h0;
  assign add_cin = w_run & r_carry;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed vector table, hand-written
// corner sequences (ignored start, reset mid-run, back-to-back), and a random regression.

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [3:0]  add_x;
  logic [3:0]  add_y;
  logic        add_cin;
  logic [3:0]  add_s;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  always #5 clk = ~clk;

  ripple_carry_adder4 u_rca (
    .x  (add_x),
    .y  (add_y),
    .ci (add_cin),
    .s  (add_s),
    .co (add_cout)
  );

  nibble_serial_adder dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .add_x    (add_x),
    .add_y    (add_y),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t        vecs[10];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_sum;
  logic        last_cout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE with fixed-latency checks. Optionally pulses start
  // with different operands during RUN, which must be ignored.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                        input logic [15:0] es, input logic ec, input bit glitch);
    a = ia; b = ib; cin = icin; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    a = ~ia; b = ib ^ 16'h5A5A; cin = ~icin;  // captured operands must not follow the inputs
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      if (glitch && k == 1) begin
        start = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b1;
      end
      if (glitch && k == 3) start = 1'b0;
      tick();                                 // E1..E3
      check("no_early_done", {31'd0, done}, 32'd0);
      check("sum_held_in_run", {16'd0, sum}, {16'd0, last_sum});
      check("cout_held_in_run", {31'd0, cout}, {31'd0, last_cout});
    end
    tick();                                   // E4
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd1);
    check("sum", {16'd0, sum}, {16'd0, es});
    check("cout", {31'd0, cout}, {31'd0, ec});
    check("adder_quiet_in_done", {23'd0, add_x, add_y, add_cin}, 32'd0);
    tick();                                   // E5
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
    check("sum_held_after_done", {15'd0, cout, sum}, {15'd0, ec, es});
    last_sum  = es;
    last_cout = ec;
  endtask

  initial begin
    logic [16:0] r;
    logic [15:0] ra, rb;
    logic        rc;
    int          cyc;
    int          gap;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    vecs[9] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};

    // Reset with start asserted in the same cycle: start must be ignored.
    rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    tick();
    tick();
    rst = 1'b0; start = 1'b0;
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_sum_cout", {15'd0, cout, sum}, 32'd0);
    check("reset_adder_inputs", {23'd0, add_x, add_y, add_cin}, 32'd0);
    tick();
    check("start_with_rst_ignored", {30'd0, busy, done}, 32'd0);
    last_sum = 16'h0000; last_cout = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, 1'b0);

    // Start pulsed during RUN with different operands: ignored, single done.
    run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("no_second_done", {30'd0, busy, done}, 32'd0);
    end

    // Reset on the second RUN cycle aborts the operation without a done pulse.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick();                                   // E1, now in 2nd RUN cycle
    rst = 1'b1;
    tick();                                   // E2 samples rst
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum_cout", {15'd0, cout, sum}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("abort_no_done", {30'd0, busy, done}, 32'd0);
    end
    last_sum = 16'h0000; last_cout = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Start held high: one operation accepted every 6 cycles.
    a = 16'h0003; b = 16'h0004; cin = 1'b1; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b2b_first_done_latency", cyc, 32'd5);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!done && cyc < 20);
    check("b2b_period", cyc, 32'd6);
    check("b2b_sum", {15'd0, cout, sum}, 32'h0008);
    start = 1'b0;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (busy && cyc < 20);
    check("b2b_drain", {31'd0, busy}, 32'd0);
    last_sum = 16'h0008; last_cout = 1'b0;

    // Random regression with random idle gaps.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(1, 0));
      r  = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) tick();
      run_op(ra, rb, rc, r[15:0], r[16], 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
